// File: rtl/sd_tx_fifo.sv
// rtl/sd_tx_fifo.sv - SD transmit FIFO: 32-bit words in, 4-bit nibbles out
//
// Stores words from the DMA/bus side in a DEPTH-word RAM and presents them one
// nibble at a time to the 4-bit SD data-line serializer.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   d, wr     write word and write strobe (ignored while full)
//   full      all DEPTH word slots occupied
//   q         current head nibble (don't-care while empty)
//   rd        pop one nibble (ignored while empty, flags underrun)
//   empty     no word available
//   clr       synchronous flush, overrides wr/rd
//   underrun  sticky: rd seen while empty
//   mem_fill  words stored, including a partially consumed head word

module sd_tx_fifo #(
  parameter int unsigned ADR_W      = 3,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      d,
  input  logic             wr,
  output logic             full,
  output logic [3:0]       q,
  input  logic             rd,
  output logic             empty,
  input  logic             clr,
  output logic             underrun,
  output logic [ADR_W:0]   mem_fill
);

  localparam int unsigned DEPTH = 1 << ADR_W;

  logic [31:0]    ram [DEPTH];
  logic [ADR_W:0] adr_i;
  logic [ADR_W:0] adr_o;
  logic [2:0]     nib;

  logic           do_wr;
  logic           do_rd;
  logic [31:0]    head;
  logic [2:0]     sel;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // when the low bits match.
  assign empty    = (adr_i == adr_o);
  assign full     = (adr_i[ADR_W-1:0] == adr_o[ADR_W-1:0]) &&
                    (adr_i[ADR_W] != adr_o[ADR_W]);
  assign mem_fill = adr_i - adr_o;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Big-endian emits d[31:28] first, so nibble index n maps to slice 7-n.
  assign head = ram[adr_o[ADR_W-1:0]];
  assign sel  = (BIG_ENDIAN != 0) ? ~nib : nib;
  assign q    = head[{sel, 2'b00} +: 4];

  // RAM is deliberately not reset; a flush also suppresses the write so the
  // cleared pointers never reference a word written in the flush cycle.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) begin
      ram[adr_i[ADR_W-1:0]] <= d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_i    <= '0;
      adr_o    <= '0;
      nib      <= '0;
      underrun <= 1'b0;
    end else if (clr) begin
      adr_i    <= '0;
      adr_o    <= '0;
      nib      <= '0;
      underrun <= 1'b0;
    end else begin
      if (do_wr) begin
        adr_i <= adr_i + 1'b1;
      end
      if (do_rd) begin
        // Last nibble of the head word releases its slot; the freed slot is
        // only seen by the writer through full on the following cycle.
        nib <= nib + 3'd1;
        if (nib == 3'd7) begin
          adr_o <= adr_o + 1'b1;
        end
      end else if (rd) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule
